// File: rtl/layer_out_serializer_pkg.sv
// Shared types for the layer output serializer: FSM encodings and the default activation width.
`ifndef ROM_bitwidth
`define ROM_bitwidth 16
`endif

package layer_out_serializer_pkg;
    localparam logic [1:0] COLLECT_ENC = 2'd0;
    localparam logic [1:0] STREAM_ENC  = 2'd1;
    localparam logic [1:0] DONE_ENC    = 2'd2;

    typedef enum logic [1:0] {
        COLLECT = COLLECT_ENC,
        STREAM  = STREAM_ENC,
        DONE    = DONE_ENC
    } state_t;
endpackage

// File: rtl/layer_out_serializer_argmax.sv
// Running argmax over a streamed frame; element 0 always loads, later ones replace only if strictly greater.
module argmax_tracker #(
    parameter int outWidth  = 16,
    parameter int idxWidth  = 5,
    parameter int signedCmp = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hs,
    input  logic                first,
    input  logic [outWidth-1:0] val,
    input  logic [idxWidth-1:0] idx,
    output logic [outWidth-1:0] next_val,
    output logic [idxWidth-1:0] next_idx
);
    logic [outWidth-1:0] best_val;
    logic [idxWidth-1:0] best_idx;
    logic                greater;

    always_comb begin
        greater = (signedCmp != 0) ? ($signed(val) > $signed(best_val)) : (val > best_val);
        if (first || greater) begin
            next_val = val;
            next_idx = idx;
        end else begin
            next_val = best_val;
            next_idx = best_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_val <= '0;
            best_idx <= '0;
        end else if (hs) begin
            best_val <= next_val;
            best_idx <= next_idx;
        end
    end
endmodule

// File: rtl/layer_out_serializer.sv
// Captures one layer's neuron activations, streams them one per handshake, and reports the frame argmax.
module layer_out_serializer
    import layer_out_serializer_pkg::*;
#(
    parameter int numNeurons = 32,
    parameter int outWidth   = `ROM_bitwidth,
    parameter int signedCmp  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [numNeurons*outWidth-1:0]   in_data,
    input  logic [numNeurons-1:0]            in_valid,
    input  logic                             out_ready,
    output logic [outWidth-1:0]              out_data,
    output logic                             out_valid,
    output logic                             out_last,
    output logic [$clog2(numNeurons)-1:0]    max_idx,
    output logic [outWidth-1:0]              max_val,
    output logic                             done,
    output logic                             overrun
);
    localparam int idxWidth = $clog2(numNeurons);
    localparam logic [idxWidth-1:0] LAST = idxWidth'(numNeurons - 1);

    state_t                 state;
    logic [outWidth-1:0]    vals [numNeurons];
    logic [numNeurons-1:0]  cap, take, cap_next;
    logic [idxWidth-1:0]    idx, idx_inc;
    logic [outWidth-1:0]    first_val, best_val;
    logic [idxWidth-1:0]    best_idx;
    logic                   hs;

    // Neurons already captured ignore further pulses; cap stays all-ones through STREAM and DONE.
    assign take     = in_valid & ~cap;
    assign cap_next = cap | take;
    assign hs       = out_valid & out_ready;
    assign idx_inc  = idx + 1'b1;
    // Element 0 may be captured on the same cycle the frame completes.
    assign first_val = take[0] ? in_data[0 +: outWidth] : vals[0];

    always_ff @(posedge clk) begin
        for (int k = 0; k < numNeurons; k++)
            if (take[k]) vals[k] <= in_data[k*outWidth +: outWidth];
    end

    argmax_tracker #(
        .outWidth (outWidth),
        .idxWidth (idxWidth),
        .signedCmp(signedCmp)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .hs      (hs),
        .first   (idx == '0),
        .val     (out_data),
        .idx     (idx),
        .next_val(best_val),
        .next_idx(best_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            cap       <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            max_idx   <= '0;
            max_val   <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (|(in_valid & cap)) overrun <= 1'b1;
            case (state)
                COLLECT: begin
                    cap <= cap_next;
                    if (&cap_next) begin
                        state     <= STREAM;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= first_val;
                        out_last  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (idx == LAST) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            max_idx   <= best_idx;
                            max_val   <= best_val;
                        end else begin
                            idx      <= idx_inc;
                            out_data <= vals[idx_inc];
                            out_last <= (idx_inc == LAST);
                        end
                    end
                end
                DONE: begin
                    cap   <= '0;
                    state <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer: table of frames plus hand sequences, stream checked against a scoreboard queue.
module tb_layer_out_serializer;
    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic           out_ready = 1'b1;

    logic [W-1:0] out_data, out_data_s, max_val, max_val_s;
    logic         out_valid, out_valid_s, out_last, out_last_s;
    logic         done, done_s, overrun, overrun_s;
    logic [1:0]   max_idx, max_idx_s;

    layer_out_serializer #(.numNeurons(N), .outWidth(W), .signedCmp(0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .out_ready(out_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .max_idx(max_idx),
        .max_val(max_val), .done(done), .overrun(overrun)
    );

    layer_out_serializer #(.numNeurons(N), .outWidth(W), .signedCmp(1)) dut_s (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .out_ready(out_ready),
        .out_data(out_data_s), .out_valid(out_valid_s), .out_last(out_last_s), .max_idx(max_idx_s),
        .max_val(max_val_s), .done(done_s), .overrun(overrun_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] val;
        logic         last;
    } exp_t;

    typedef struct {
        logic [N-1:0][W-1:0] d;
        int                  mode;
        int                  ui;
        logic [W-1:0]        uv;
        int                  si;
        logic [W-1:0]        sv;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;
    logic         stall_prev;
    logic [W-1:0] data_prev;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, b, c, e, input int mode,
                                input int ui, input logic [W-1:0] uv, input int si, input logic [W-1:0] sv);
        vec_t v;
        v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = e;
        v.mode = mode; v.ui = ui; v.uv = uv; v.si = si; v.sv = sv;
        return v;
    endfunction

    task automatic push_frame(input logic [N-1:0][W-1:0] d);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.val  = d[k];
            e.last = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock: score any handshake seen on the current outputs, then advance to just past the edge.
    task automatic cyc();
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_element", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_data", out_data, e.val);
                chk("stream_last", out_last, e.last);
            end
        end
        stall_prev = !rst && out_valid && !out_ready;
        data_prev  = out_data;
        @(posedge clk);
        #1;
        if (stall_prev) begin
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_data", out_data, data_prev);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '0; out_ready = 1'b1;
        cyc(); cyc();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic finish_frame(input int mode, input bit lat, input int ui, input logic [W-1:0] uv,
                                input int si, input logic [W-1:0] sv);
        int n = 0;
        bit got = 0;
        while (n < 40 && !got) begin
            out_ready = (mode == 0) || (n % 3 == 0);
            cyc();
            n++;
            got = done;
        end
        out_ready = 1'b1;
        chk("done_seen", got, 1);
        if (lat) chk("done_latency", n, 4);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_signed_dut", done_s, 1);
        chk("max_idx_unsigned", max_idx, ui);
        chk("max_val_unsigned", max_val, uv);
        chk("max_idx_signed", max_idx_s, si);
        chk("max_val_signed", max_val_s, sv);
        cyc();
        chk("done_one_cycle", done, 0);
        chk("max_idx_hold", max_idx, ui);
    endtask

    task automatic run_frame(input vec_t v);
        in_data  = v.d;
        in_valid = '1;
        push_frame(v.d);
        cyc();
        in_valid = '0;
        chk("first_valid", out_valid, 1);
        chk("first_data", out_data, v.d[0]);
        finish_frame(v.mode, v.mode == 0, v.ui, v.uv, v.si, v.sv);
    endtask

    initial begin
        logic [N-1:0][W-1:0] d;
        logic [N-1:0]        mask;

        vecs[0] = mk(16'd10, 16'd40, 16'd40, 16'd5, 0, 1, 16'd40, 1, 16'd40);
        vecs[1] = mk(16'hFFF0, 16'h0003, 16'h8000, 16'h0003, 0, 0, 16'hFFF0, 1, 16'h0003);
        vecs[2] = mk(16'd7, 16'd7, 16'd7, 16'd7, 1, 0, 16'd7, 0, 16'd7);
        vecs[3] = mk(16'd1, 16'd2, 16'd3, 16'hFFFF, 1, 3, 16'hFFFF, 2, 16'd3);
        vecs[4] = mk(16'd9, 16'd3, 16'd12, 16'd1, 0, 2, 16'd12, 2, 16'd12);

        rst = 1'b1;
        cyc(); cyc();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_done", done, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_max_idx", max_idx, 0);
        chk("reset_max_val", max_val, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);
        chk("no_overrun_clean_frames", overrun, 0);

        // Staggered capture: neurons 3,0,2,1 on cycles 0,2,5,9.
        do_reset();
        d[0] = 16'd11; d[1] = 16'd22; d[2] = 16'd33; d[3] = 16'd44;
        in_data = d;
        for (int c = 0; c < 10; c++) begin
            mask = (c == 0) ? 4'b1000 : (c == 2) ? 4'b0001 : (c == 5) ? 4'b0100 : (c == 9) ? 4'b0010 : 4'b0000;
            in_valid = mask;
            if (c == 9) push_frame(d);
            cyc();
            in_valid = '0;
            if (c < 9) chk("stagger_idle", out_valid, 0);
            else       chk("stagger_first_valid", out_valid, 1);
        end
        finish_frame(0, 0, 3, 16'd44, 3, 16'd44);

        // Re-pulse of a captured neuron during the stream.
        do_reset();
        d[0] = 16'd100; d[1] = 16'd200; d[2] = 16'd300; d[3] = 16'd400;
        in_data = d; in_valid = '1;
        push_frame(d);
        cyc();
        chk("overrun_before", overrun, 0);
        in_valid = 4'b0100;
        in_data[2*W +: W] = 16'd999;
        cyc();
        in_valid = '0;
        chk("overrun_set", overrun, 1);
        finish_frame(0, 0, 3, 16'd400, 3, 16'd400);
        cyc(); cyc();
        chk("overrun_sticky", overrun, 1);
        do_reset();
        chk("overrun_cleared_by_rst", overrun, 0);

        // Reset while element 2 is presented.
        d[0] = 16'd1; d[1] = 16'd2; d[2] = 16'd3; d[3] = 16'd4;
        in_data = d; in_valid = '1;
        push_frame(d);
        cyc();
        in_valid = '0;
        cyc(); cyc();
        chk("midstream_elem2", out_data, 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        chk("midstream_rst_valid", out_valid, 0);
        chk("midstream_rst_max_idx", max_idx, 0);
        chk("midstream_rst_max_val", max_val, 0);
        for (int c = 0; c < 8; c++) begin
            cyc();
            chk("midstream_no_done", done, 0);
        end
        run_frame(vecs[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
